video_frame_arbiter: RTL and testbench
======================================

VIDEO_FRAME_ARBITER -- requirements
Module: video_frame_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, stream data width in bits.
REQ-002 Parameter GAP, default 2, idle cycles inserted after each completed frame (range 0..15).
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  permits new frame grants when high.
REQ-006 req  in  2  level request per source; bit i means "run source i".
REQ-007 start0, start1  out  1  one-cycle start pulse to source 0 / source 1.
REQ-008 s0_tdata/s1_tdata  in  DATA_W; s0_tvalid/s1_tvalid, s0_tlast/s1_tlast  in  1; s0_tready/s1_tready  out  1; per-source stream inputs.
REQ-009 m_tdata  out  DATA_W; m_tvalid, m_tlast  out  1; m_tready  in  1; merged output stream.
REQ-010 grant  out  2  one-hot owner of the current frame; 2'b00 when none.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 frame_done  out  1  one-cycle pulse per completed frame.

Function
REQ-013 FSM states: IDLE, START, STREAM, GAP.
REQ-014 IDLE: if enable=1 and req!=0, load grant and go to START next cycle; otherwise stay.
REQ-015 Arbitration is round-robin per frame: the source granted last has lowest priority; after reset source 0 has priority.
REQ-016 Only one request pending -> that source is granted regardless of priority.
REQ-017 START: assert start0 or start1 (matching grant) for exactly one cycle, then go to STREAM.
REQ-018 STREAM: m_tdata/m_tvalid/m_tlast = granted source's signals combinationally; granted sN_tready = m_tready; non-granted sN_tready = 0.
REQ-019 Outside STREAM: m_tvalid=0, m_tlast=0, m_tdata=0, both sN_tready=0.
REQ-020 A beat transfers when m_tvalid && m_tready; on a beat with m_tlast=1 go to GAP (GAP>0) or IDLE (GAP=0) and pulse frame_done the following cycle.
REQ-021 GAP: 4-bit counter loaded with GAP-1 on entry, decrements each cycle, exit to IDLE when counter is 0 (exactly GAP cycles in GAP).
REQ-022 grant holds its value from IDLE exit through GAP and clears to 0 on return to IDLE.
REQ-023 enable or req deasserting during START/STREAM/GAP does not abort the frame; they are sampled only in IDLE.
REQ-024 Beats from a non-granted source are ignored; its tready stays 0.
REQ-025 Back-to-back frames: minimum 2+GAP cycles between last beat of one frame and first possible beat of the next (GAP + IDLE + START).

Reset
REQ-026 rstn low asynchronously forces state=IDLE, grant=0, start0=start1=0, frame_done=0, GAP counter=0, priority to source 0, frame_cnt=0 (if present).
REQ-027 Reset mid-frame abandons the frame with no frame_done pulse; combinational outputs follow REQ-019 while rstn is low.
REQ-028 First grant possible on the first posedge clk after rstn deasserts.

Configuration
REQ-029 Macro FRAME_CNT_EN: when defined, adds output frame_cnt (16 bits) incremented with each frame_done pulse, wrapping 16'hFFFF -> 0.
REQ-030 Without FRAME_CNT_EN the port and counter do not exist; all other behaviour is identical.

Verification
REQ-031 req=2'b01, enable=1, 160-beat frame from source 0 with m_tready=1 -> start0 pulse 1 cycle after IDLE exit, 160 beats out, frame_done once, grant=00 after 2 GAP cycles.
REQ-032 req=2'b11 held, 4 frames -> grant sequence 01,10,01,10; start pulses alternate.
REQ-033 m_tready toggled 1/0 each cycle in STREAM -> granted tready mirrors m_tready, data order preserved, non-granted tready always 0.
REQ-034 rstn pulsed low at beat 50 of a frame -> outputs immediately at reset values, no frame_done, next grant goes to source 0.
REQ-035 enable dropped at beat 10 -> frame completes to tlast, then no new grant while enable=0 despite req=2'b11.
REQ-036 FRAME_CNT_EN defined, 3 frames completed -> frame_cnt=3; GAP=0 build -> IDLE entered the cycle after the tlast beat.

Source files
------------

// File: rtl/video_frame_arbiter.sv
// video_frame_arbiter: per-frame round-robin arbiter merging two AXI-stream sources into one.
// Define FRAME_CNT_EN to add a 16-bit completed-frame counter output (frame_cnt).
module video_frame_arbiter #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [1:0]        req,
  output logic              start0,
  output logic              start1,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              frame_done
`ifdef FRAME_CNT_EN
  , output logic [15:0]     frame_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state_r;
  logic [3:0] gap_cnt_r;
  logic       last_r;      // 1: source 1 was granted last, so source 0 wins a tie
  logic [1:0] pick_s;
  logic       beat_s;

  // Round-robin pick among pending requests
  always_comb begin
    pick_s = 2'b00;
    case (req)
      2'b01:   pick_s = 2'b01;
      2'b10:   pick_s = 2'b10;
      2'b11:   pick_s = last_r ? 2'b01 : 2'b10;
      default: pick_s = 2'b00;
    endcase
  end

  // Stream mux: only the granted source is visible, and only while streaming
  always_comb begin
    m_tdata   = {DATA_W{1'b0}};
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    if (state_r == ST_STREAM && grant[0]) begin
      m_tdata   = s0_tdata;
      m_tvalid  = s0_tvalid;
      m_tlast   = s0_tlast;
      s0_tready = m_tready;
    end else if (state_r == ST_STREAM && grant[1]) begin
      m_tdata   = s1_tdata;
      m_tvalid  = s1_tvalid;
      m_tlast   = s1_tlast;
      s1_tready = m_tready;
    end else begin
      m_tdata   = {DATA_W{1'b0}};
      m_tvalid  = 1'b0;
      m_tlast   = 1'b0;
    end
  end

  assign beat_s = m_tvalid && m_tready;

  // Frame FSM with registered grant, start pulses, busy and completion pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      gap_cnt_r  <= 4'd0;
      last_r     <= 1'b1;
      grant      <= 2'b00;
      start0     <= 1'b0;
      start1     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FRAME_CNT_EN
      frame_cnt  <= 16'd0;
`endif
    end else begin
      start0     <= 1'b0;
      start1     <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable && pick_s != 2'b00) begin
            grant   <= pick_s;
            start0  <= pick_s[0];
            start1  <= pick_s[1];
            last_r  <= pick_s[1];
            busy    <= 1'b1;
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          state_r <= ST_STREAM;
        end
        ST_STREAM: begin
          if (beat_s && m_tlast) begin
            frame_done <= 1'b1;
`ifdef FRAME_CNT_EN
            frame_cnt  <= frame_cnt + 16'd1;
`endif
            if (GAP == 0) begin
              state_r <= ST_IDLE;
              grant   <= 2'b00;
              busy    <= 1'b0;
            end else begin
              state_r   <= ST_GAP;
              gap_cnt_r <= GAP_LOAD;
            end
          end else begin
            state_r <= ST_STREAM;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == 4'd0) begin
            state_r <= ST_IDLE;
            grant   <= 2'b00;
            busy    <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant   <= 2'b00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_arbiter.sv
// Directed self-checking bench for video_frame_arbiter (GAP=2 main instance, GAP=0 side instance).
module tb_video_frame_arbiter;

  localparam int DW     = 8;
  localparam int TB_GAP = 2;

  logic          clk;
  logic          rstn, enable, m_tready;
  logic [1:0]    req, grant;
  logic          start0, start1, busy, frame_done;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready, s1_tvalid, s1_tlast, s1_tready;
  logic          m_tvalid, m_tlast;
`ifdef FRAME_CNT_EN
  logic [15:0]   frame_cnt, g0_frame_cnt;
`endif

  logic          g0_enable, g0_m_tready, g0_start0, g0_start1, g0_busy, g0_frame_done;
  logic [1:0]    g0_req, g0_grant;
  logic [DW-1:0] g0_s0_tdata, g0_s1_tdata, g0_m_tdata;
  logic          g0_s0_tvalid, g0_s0_tlast, g0_s0_tready, g0_s1_tvalid, g0_s1_tlast, g0_s1_tready;
  logic          g0_m_tvalid, g0_m_tlast;

  int total  = 0;
  int passed = 0;
  int fd_count = 0;

  video_frame_arbiter #(.DATA_W(DW), .GAP(TB_GAP)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req),
    .start0(start0), .start1(start1),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .busy(busy), .frame_done(frame_done)
`ifdef FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  video_frame_arbiter #(.DATA_W(DW), .GAP(0)) dut_g0 (
    .clk(clk), .rstn(rstn), .enable(g0_enable), .req(g0_req),
    .start0(g0_start0), .start1(g0_start1),
    .s0_tdata(g0_s0_tdata), .s0_tvalid(g0_s0_tvalid), .s0_tlast(g0_s0_tlast), .s0_tready(g0_s0_tready),
    .s1_tdata(g0_s1_tdata), .s1_tvalid(g0_s1_tvalid), .s1_tlast(g0_s1_tlast), .s1_tready(g0_s1_tready),
    .m_tdata(g0_m_tdata), .m_tvalid(g0_m_tvalid), .m_tlast(g0_m_tlast), .m_tready(g0_m_tready),
    .grant(g0_grant), .busy(g0_busy), .frame_done(g0_frame_done)
`ifdef FRAME_CNT_EN
    , .frame_cnt(g0_frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  function automatic logic [7:0] pattern(input int src, input int idx);
    return 8'(idx * 5 + src * 128 + 3);
  endfunction

  task automatic drive_src(input int src, input int idx, input int len);
    if (src == 0) begin
      s0_tvalid = 1'b1; s0_tdata = pattern(0, idx); s0_tlast = (idx == len - 1);
      s1_tvalid = 1'b1; s1_tdata = 8'hEE;           s1_tlast = 1'b1;
    end else begin
      s1_tvalid = 1'b1; s1_tdata = pattern(1, idx); s1_tlast = (idx == len - 1);
      s0_tvalid = 1'b1; s0_tdata = 8'hEE;           s0_tlast = 1'b1;
    end
  endtask

  task automatic idle_src();
    s0_tvalid = 1'b0; s0_tdata = 8'h00; s0_tlast = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = 8'h00; s1_tlast = 1'b0;
  endtask

  // Runs one frame from src; optional ready toggling, reset at a beat, enable drop at a beat.
  task automatic stream_frame(input int src, input int len, input bit tog, input int rst_at,
                              input int drop_at, input bit keep_req);
    logic [1:0] g;
    logic [7:0] expd;
    logic       rdy_g, rdy_o;
    int idx, cyc;
    bit beat;
    g = (src == 0) ? 2'b01 : 2'b10;
    idx = 0; cyc = 0;
    drive_src(src, 0, len);
    m_tready = 1'b1;
    do begin @(negedge clk); cyc++; end while (start0 !== 1'b1 && start1 !== 1'b1 && cyc < 8);
    total++;
    if ({start1, start0} !== g || grant !== g)
      $display("FAIL start_src%0d: start=%b grant=%b expected %b", src, {start1, start0}, grant, g);
    else passed++;
    total++;
    if (m_tvalid !== 1'b0 || busy !== 1'b1 || s0_tready !== 1'b0 || s1_tready !== 1'b0)
      $display("FAIL start_state: m_tvalid=%b busy=%b tready=%b%b expected 0 1 00", m_tvalid, busy, s1_tready, s0_tready);
    else passed++;
    if (!keep_req) req = 2'b00;
    @(posedge clk); #1;
    cyc = 0;
    while (idx < len && cyc < 4 * len + 20) begin
      @(negedge clk); cyc++;
      expd  = pattern(src, idx);
      rdy_g = (src == 0) ? s0_tready : s1_tready;
      rdy_o = (src == 0) ? s1_tready : s0_tready;
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== expd || m_tlast !== (idx == len - 1) || {start1, start0} !== 2'b00)
        $display("FAIL beat%0d: valid=%b data=%h last=%b start=%b expected 1 %h %b 00",
                 idx, m_tvalid, m_tdata, m_tlast, {start1, start0}, expd, (idx == len - 1));
      else passed++;
      total++;
      if (rdy_g !== m_tready || rdy_o !== 1'b0)
        $display("FAIL tready%0d: granted=%b other=%b expected %b 0", idx, rdy_g, rdy_o, m_tready);
      else passed++;
      beat = m_tready;
      if (idx == rst_at) begin
        rstn = 1'b0; #1;
        total++;
        if (grant !== 2'b00 || busy !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00 ||
            s0_tready !== 1'b0 || s1_tready !== 1'b0 || frame_done !== 1'b0)
          $display("FAIL reset_mid: grant=%b busy=%b valid=%b data=%h tready=%b%b done=%b expected all 0",
                   grant, busy, m_tvalid, m_tdata, s1_tready, s0_tready, frame_done);
        else passed++;
        idle_src();
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if (beat) idx++;
      if (idx == drop_at) enable = 1'b0;
      if (tog) m_tready = ~m_tready;
      if (idx < len) drive_src(src, idx, len); else idle_src();
    end
    total++;
    if (idx != len) $display("FAIL beat_count: got %0d expected %0d", idx, len);
    else passed++;
    for (int i = 0; i < TB_GAP; i++) begin
      @(negedge clk);
      total++;
      if (grant !== g || busy !== 1'b1 || frame_done !== (i == 0) || m_tvalid !== 1'b0)
        $display("FAIL gap%0d: grant=%b busy=%b done=%b valid=%b expected %b 1 %b 0",
                 i, grant, busy, frame_done, m_tvalid, g, (i == 0));
      else passed++;
    end
    @(negedge clk);
    total++;
    if (grant !== 2'b00 || busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL idle_return: grant=%b busy=%b done=%b expected 00 0 0", grant, busy, frame_done);
    else passed++;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; req = 2'b01; m_tready = 1'b1;
    drive_src(0, 0, 4);
    repeat (2) @(negedge clk);
    total++;
    if (grant !== 2'b00 || busy !== 1'b0 || {start1, start0} !== 2'b00 || frame_done !== 1'b0)
      $display("FAIL reset_regs: grant=%b busy=%b start=%b done=%b expected 00 0 00 0",
               grant, busy, {start1, start0}, frame_done);
    else passed++;
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || s0_tready !== 1'b0 || s1_tready !== 1'b0)
      $display("FAIL reset_stream: valid=%b data=%h tready=%b%b expected 0 00 00", m_tvalid, m_tdata, s1_tready, s0_tready);
    else passed++;
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (start0 !== 1'b1 || grant !== 2'b01)
      $display("FAIL first_grant: start0=%b grant=%b expected 1 01", start0, grant);
    else passed++;
    req = 2'b00; enable = 1'b0; idle_src();
    rstn = 1'b0; #1;
    total++;
    if (grant !== 2'b00 || start0 !== 1'b0 || busy !== 1'b0)
      $display("FAIL async_reset: grant=%b start0=%b busy=%b expected 00 0 0", grant, start0, busy);
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int fd0;
    fd0 = fd_count;
    enable = 1'b1; req = 2'b11;
    for (int k = 0; k < 4; k++) stream_frame(k % 2, 6, 1'b0, -1, -1, (k < 3));
    @(posedge clk); #1;
    total++;
    if (fd_count - fd0 != 4) $display("FAIL rr_done_count: got %0d expected 4", fd_count - fd0);
    else passed++;
  endtask

  task automatic test_single_frame();
    int fd0;
    fd0 = fd_count;
    enable = 1'b1; req = 2'b01;
    stream_frame(0, 160, 1'b0, -1, -1, 1'b0);
    @(posedge clk); #1;
    total++;
    if (fd_count - fd0 != 1) $display("FAIL single_done_count: got %0d expected 1", fd_count - fd0);
    else passed++;
  endtask

  task automatic test_ready_toggle();
    enable = 1'b1; req = 2'b10;
    stream_frame(1, 12, 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    fd0 = fd_count;
    enable = 1'b1; req = 2'b01;
    stream_frame(0, 80, 1'b0, 50, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (fd_count != fd0) $display("FAIL reset_no_done: got %0d pulses expected 0", fd_count - fd0);
    else passed++;
    req = 2'b11;
    stream_frame(0, 5, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_enable_drop();
    enable = 1'b1; req = 2'b11;
    stream_frame(1, 20, 1'b0, -1, 10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (grant !== 2'b00 || busy !== 1'b0 || {start1, start0} !== 2'b00)
        $display("FAIL enable_low%0d: grant=%b busy=%b start=%b expected 00 0 00", i, grant, busy, {start1, start0});
      else passed++;
    end
    req = 2'b00; enable = 1'b1;
  endtask

  task automatic test_frame_cnt();
    enable = 1'b1; req = 2'b01;
    stream_frame(0, 3, 1'b0, -1, -1, 1'b0);
`ifdef FRAME_CNT_EN
    total++;
    if (frame_cnt !== 16'd3) $display("FAIL frame_cnt: got %0d expected 3", frame_cnt);
    else passed++;
`endif
  endtask

  task automatic test_gap_zero();
    int cyc;
    g0_enable = 1'b1; g0_req = 2'b01; g0_m_tready = 1'b1;
    g0_s0_tvalid = 1'b1; g0_s0_tdata = pattern(0, 0); g0_s0_tlast = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (g0_start0 !== 1'b1 && cyc < 8);
    total++;
    if (g0_start0 !== 1'b1 || g0_grant !== 2'b01)
      $display("FAIL g0_start: start0=%b grant=%b expected 1 01", g0_start0, g0_grant);
    else passed++;
    g0_req = 2'b00;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (g0_m_tvalid !== 1'b1 || g0_m_tdata !== pattern(0, i) || g0_m_tlast !== (i == 2))
        $display("FAIL g0_beat%0d: valid=%b data=%h last=%b expected 1 %h %b",
                 i, g0_m_tvalid, g0_m_tdata, g0_m_tlast, pattern(0, i), (i == 2));
      else passed++;
      @(posedge clk); #1;
      g0_s0_tdata = pattern(0, i + 1); g0_s0_tlast = (i + 1 == 2); g0_s0_tvalid = (i < 2);
    end
    @(negedge clk);
    total++;
    if (g0_busy !== 1'b0 || g0_grant !== 2'b00 || g0_frame_done !== 1'b1)
      $display("FAIL g0_idle_after_last: busy=%b grant=%b done=%b expected 0 00 1", g0_busy, g0_grant, g0_frame_done);
    else passed++;
`ifdef FRAME_CNT_EN
    total++;
    if (g0_frame_cnt !== 16'd1) $display("FAIL g0_frame_cnt: got %0d expected 1", g0_frame_cnt);
    else passed++;
`endif
    g0_enable = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; req = 2'b00; m_tready = 1'b0;
    idle_src();
    g0_enable = 1'b0; g0_req = 2'b00; g0_m_tready = 1'b0;
    g0_s0_tdata = 8'h00; g0_s0_tvalid = 1'b0; g0_s0_tlast = 1'b0;
    g0_s1_tdata = 8'h00; g0_s1_tvalid = 1'b0; g0_s1_tlast = 1'b0;
    test_reset();
    test_round_robin();
    test_single_frame();
    test_ready_toggle();
    test_reset_mid_frame();
    test_enable_drop();
    test_frame_cnt();
    test_gap_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
